dsn_rat_seq: RTL and testbench

//  Read-ROM sequencer for the RAT digital serial number chip; sits directly upstream of dsn_rat.
//  On a go request it runs the whole transaction through dsn_rat's start/busy handshake:
//    - one init slot;
//    - eight write slots carrying Read-ROM command 0x33, LSB first;
//    - 64 read slots.
//  It assembles the 64-bit ROM, checks its CRC-8, and presents the result to VME registers.

---
 rtl/dsn_rat_seq.sv | 144 ++++++++++++++
 tb/tb_dsn_rat_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsn_rat_seq.sv
`timescale 1ns/1ps
// Read-ROM sequencer in front of dsn_rat: init slot, 8 command slots, 64 read slots; assembles and CRC-checks the ROM.
// Latency: 73 slots per go; each slot waits on dsn_rat busy, with a watchdog abort if dsn_rat never answers.
module dsn_rat_seq #(
    parameter int         MXWDOG  = 18,
    parameter logic [7:0] CMD_ROM = 8'h33
) (
    input  logic        clock,
    input  logic        global_reset,
    input  logic        go,
    output logic        dsn_start,
    output logic        dsn_wr_data,
    output logic        dsn_wr_init,
    input  logic        dsn_busy,
    input  logic        dsn_rd_data,
    output logic [63:0] dsn_data,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        error
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_CMD, S_RD, S_FIN} main_t;
    typedef enum logic [1:0] {T_REQ, T_RUN, T_REL, T_GAP} slot_t;

    localparam logic [MXWDOG-1:0] WDOG_ONE = 1;

    main_t             main_st;
    slot_t             slot_st;
    logic [5:0]        bit_cnt;
    logic [7:0]        crc;
    logic [MXWDOG-1:0] wdog;

    logic       rd_fb;
    logic [7:0] crc_nxt;
    logic [2:0] cmd_idx;
    logic       slot_last;
    logic       wdog_full;

    always_comb begin
        rd_fb     = crc[0] ^ dsn_rd_data;
        crc_nxt   = (crc >> 1) ^ (rd_fb ? 8'h8C : 8'h00);
        cmd_idx   = bit_cnt[2:0] + 3'd1;
        wdog_full = (wdog == '1);
        slot_last = (main_st == S_INIT)
                  || (main_st == S_CMD && bit_cnt == 6'd7)
                  || (main_st == S_RD  && bit_cnt == 6'd63);
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            main_st     <= S_IDLE;
            slot_st     <= T_REQ;
            bit_cnt     <= '0;
            crc         <= '0;
            wdog        <= '0;
            dsn_start   <= 1'b0;
            dsn_wr_data <= 1'b0;
            dsn_wr_init <= 1'b0;
            dsn_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            crc_ok      <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (main_st)
                S_IDLE, S_FIN: begin
                    if (go) begin
                        main_st     <= S_INIT;
                        slot_st     <= T_REQ;
                        bit_cnt     <= '0;
                        crc         <= '0;
                        wdog        <= '0;
                        dsn_data    <= '0;
                        done        <= 1'b0;
                        crc_ok      <= 1'b0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        dsn_start   <= 1'b1;
                        dsn_wr_init <= 1'b1;
                        dsn_wr_data <= 1'b0;
                    end
                end
                S_INIT, S_CMD, S_RD: begin
                    case (slot_st)
                        T_REQ, T_RUN: begin
                            if (wdog_full) begin
                                // dsn_rat never completed the slot: abort, keep partial data
                                main_st   <= S_FIN;
                                dsn_start <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                crc_ok    <= 1'b0;
                                error     <= 1'b1;
                            end else begin
                                wdog <= wdog + WDOG_ONE;
                                if (slot_st == T_REQ) begin
                                    if (dsn_busy)
                                        slot_st <= T_RUN;
                                end else if (!dsn_busy) begin
                                    slot_st   <= T_REL;
                                    dsn_start <= 1'b0;
                                    if (main_st == S_RD) begin
                                        dsn_data <= {dsn_rd_data, dsn_data[63:1]};
                                        crc      <= crc_nxt;
                                    end
                                end
                            end
                        end
                        T_REL: slot_st <= T_GAP;
                        default: begin
                            slot_st <= T_REQ;
                            wdog    <= '0;
                            if (!slot_last) begin
                                bit_cnt   <= bit_cnt + 6'd1;
                                dsn_start <= 1'b1;
                                if (main_st == S_CMD)
                                    dsn_wr_data <= CMD_ROM[cmd_idx];
                            end else if (main_st == S_INIT) begin
                                main_st     <= S_CMD;
                                bit_cnt     <= '0;
                                dsn_start   <= 1'b1;
                                dsn_wr_init <= 1'b0;
                                dsn_wr_data <= CMD_ROM[0];
                            end else if (main_st == S_CMD) begin
                                main_st     <= S_RD;
                                bit_cnt     <= '0;
                                dsn_start   <= 1'b1;
                                dsn_wr_data <= 1'b1;
                            end else begin
                                main_st <= S_FIN;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                crc_ok  <= (crc == 8'h00);
                            end
                        end
                    endcase
                end
                default: main_st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsn_rat_seq.sv
`timescale 1ns/1ps
// Bench for dsn_rat_seq with a behavioural dsn_rat/ROM stand-in and a handshake monitor.
module tb_dsn_rat_seq;

    logic        clock = 1'b0;
    logic        global_reset;
    logic        go;
    logic        dsn_start, dsn_wr_data, dsn_wr_init;
    logic        dsn_busy, dsn_rd_data;
    logic [63:0] dsn_data;
    logic        busy, done, crc_ok, error;

    always #12 clock = ~clock;

    dsn_rat_seq #(.MXWDOG(6), .CMD_ROM(8'h33)) dut (
        .clock        (clock),
        .global_reset (global_reset),
        .go           (go),
        .dsn_start    (dsn_start),
        .dsn_wr_data  (dsn_wr_data),
        .dsn_wr_init  (dsn_wr_init),
        .dsn_busy     (dsn_busy),
        .dsn_rd_data  (dsn_rd_data),
        .dsn_data     (dsn_data),
        .busy         (busy),
        .done         (done),
        .crc_ok       (crc_ok),
        .error        (error)
    );

    // dsn_rat + ROM stand-in: busy one clock after start, rd_data valid when busy falls
    logic [63:0] rom = '0;
    logic        model_dead = 1'b0;
    int          m_slot;
    int          m_cnt;
    logic [1:0]  m_st;
    logic [7:0]  cmd_seen;

    always @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            dsn_busy    <= 1'b0;
            dsn_rd_data <= 1'b0;
            m_st        <= 2'd0;
            m_slot      <= 0;
            m_cnt       <= 0;
            cmd_seen    <= '0;
        end else begin
            case (m_st)
                2'd0: if (dsn_start && !model_dead) begin
                    dsn_busy <= 1'b1;
                    m_cnt    <= 3;
                    m_st     <= 2'd1;
                    if (dsn_wr_init) begin
                        m_slot   <= 0;
                        cmd_seen <= '0;
                    end else begin
                        m_slot <= m_slot + 1;
                        if (m_slot < 8) cmd_seen[m_slot[2:0]] <= dsn_wr_data;
                    end
                end
                2'd1: if (m_cnt == 0) begin
                    dsn_busy    <= 1'b0;
                    dsn_rd_data <= (m_slot >= 9) ? rom[6'(m_slot - 9)] : 1'b1;
                    m_st        <= 2'd2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (!dsn_start) m_st <= 2'd0;
            endcase
        end
    end

    // Handshake monitor
    int   start_rises = 0;
    int   viol_busy = 0, viol_gap = 0, viol_wr = 0;
    int   low_run = 0;
    logic prev_start = 0, prev_wd = 0, prev_wi = 0, prev_busy = 0, prev_rst = 0;

    always @(negedge clock) begin
        if (dsn_start && !prev_start) begin
            start_rises++;
            if (dsn_busy) viol_busy++;
            if (prev_busy && low_run != 2) viol_gap++;
        end
        if (!global_reset && !prev_rst && !(dsn_start && !prev_start)
            && (dsn_wr_data != prev_wd || dsn_wr_init != prev_wi))
            viol_wr++;
        low_run    = dsn_start ? 0 : low_run + 1;
        prev_start = dsn_start;
        prev_wd    = dsn_wr_data;
        prev_wi    = dsn_wr_init;
        prev_busy  = busy;
        prev_rst   = global_reset;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_go();
        @(negedge clock);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
    endtask

    typedef struct {
        logic [63:0] rom;
        logic [63:0] exp_data;
        logic        exp_crc_ok;
    } vec_t;

    vec_t vecs[4];
    localparam logic [63:0] ROM_OK = 64'hA200_0000_01B8_1C02;

    initial begin
        bit seen;
        int n0;

        vecs[0] = '{ROM_OK,                 ROM_OK,                 1'b1};
        vecs[1] = '{64'hA300_0000_01B8_1C02, 64'hA300_0000_01B8_1C02, 1'b0};
        vecs[2] = '{64'h0,                  64'h0,                  1'b1};
        vecs[3] = '{64'h1,                  64'h1,                  1'b0};

        global_reset = 1'b1;
        go = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {dsn_start, dsn_wr_data, dsn_wr_init, busy, done, crc_ok, error}, 64'h0);
        check("reset_data", dsn_data, 64'h0);
        global_reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int v = 0; v < 4; v++) begin
            rom = vecs[v].rom;
            n0  = start_rises;
            pulse_go();
            check($sformatf("v%0d_busy_running", v), {63'b0, busy}, 64'h1);
            wait_done(2000, seen);
            check($sformatf("v%0d_done", v), {63'b0, seen}, 64'h1);
            check($sformatf("v%0d_data", v), dsn_data, vecs[v].exp_data);
            check($sformatf("v%0d_crc_ok", v), {63'b0, crc_ok}, {63'b0, vecs[v].exp_crc_ok});
            check($sformatf("v%0d_error", v), {63'b0, error}, 64'h0);
            check($sformatf("v%0d_busy_end", v), {63'b0, busy}, 64'h0);
            check($sformatf("v%0d_starts", v), 64'(start_rises - n0), 64'd73);
            check($sformatf("v%0d_cmd", v), {56'b0, cmd_seen}, 64'h33);
            repeat (5) @(negedge clock);
            check($sformatf("v%0d_hold", v), {62'b0, done, crc_ok}, {62'b0, 1'b1, vecs[v].exp_crc_ok});
        end

        // Watchdog: dsn_rat never answers, abort once the counter saturates at 63
        model_dead = 1'b1;
        pulse_go();
        repeat (60) @(negedge clock);
        check("wdog_not_early", {62'b0, error, dsn_start}, 64'h1);
        wait_done(10, seen);
        check("wdog_done", {63'b0, seen}, 64'h1);
        check("wdog_flags", {59'b0, error, dsn_start, busy, crc_ok, done}, 64'h11);
        check("wdog_data", dsn_data, 64'h0);
        model_dead = 1'b0;
        repeat (3) @(negedge clock);

        // Asynchronous reset in the middle of read slot 20
        rom = ROM_OK;
        pulse_go();
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clock);
            if (m_slot == 29 && dsn_busy) seen = 1'b1;
        end
        check("rst_reach_slot20", {62'b0, seen, busy}, 64'h3);
        #3 global_reset = 1'b1;
        #1;
        check("rst_async_outputs", {dsn_start, dsn_wr_data, dsn_wr_init, busy, done, crc_ok, error}, 64'h0);
        check("rst_async_data", dsn_data, 64'h0);
        repeat (2) @(negedge clock);
        global_reset = 1'b0;
        repeat (2) @(negedge clock);
        pulse_go();
        wait_done(2000, seen);
        check("rst_after_done", {63'b0, seen}, 64'h1);
        check("rst_after_data", dsn_data, ROM_OK);
        check("rst_after_crc", {62'b0, crc_ok, error}, 64'h2);

        // go held high: back-to-back transactions
        @(negedge clock);
        go = 1'b1;
        for (int t = 0; t < 2; t++) begin
            wait_done(2000, seen);
            check($sformatf("b2b%0d_done", t), {63'b0, seen}, 64'h1);
            check($sformatf("b2b%0d_data", t), dsn_data, ROM_OK);
            check($sformatf("b2b%0d_crc", t), {63'b0, crc_ok}, 64'h1);
            @(negedge clock);
            check($sformatf("b2b%0d_restart", t), {62'b0, busy, done}, 64'h2);
        end
        go = 1'b0;
        wait_done(2000, seen);
        check("b2b_final_done", {63'b0, seen}, 64'h1);

        check("hs_start_while_busy", 64'(viol_busy), 64'h0);
        check("hs_gap_two_clocks", 64'(viol_gap), 64'h0);
        check("hs_wr_stable", 64'(viol_wr), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
